// File: rtl/ttl_74595.sv
// 74HC595-style serial-in shift register with a parallel storage register.
// SRCLK/RCLK are pin strobes edge-detected inside the single Clk domain.
module ttl_74595 #(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SER,
  input  logic             SRCLK,
  input  logic             RCLK,
  input  logic             SRCLR_bar,
  input  logic             OE_bar,
  output logic [WIDTH-1:0] Q,
  output logic             Q_oe,
  output logic             QH_prime
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] st;
  logic             srclk_d;
  logic             rclk_d;
  logic             sh_ev;
  logic             ld_ev;

  // Delays only matter to event-driven chip models; negative values are meaningless.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_delay_ignored
  end

  assign sh_ev = SRCLK & ~srclk_d;
  assign ld_ev = RCLK & ~rclk_d;

  // History flops reset high so a strobe held through reset must drop before it counts.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr      <= '0;
      st      <= '0;
      srclk_d <= 1'b1;
      rclk_d  <= 1'b1;
    end else begin
      srclk_d <= SRCLK;
      rclk_d  <= RCLK;
      if (!SRCLR_bar) begin
        sr <= '0;
      end else if (sh_ev) begin
        sr <= {sr[WIDTH-2:0], SER};
      end
      if (ld_ev) begin
        st <= sr;
      end
    end
  end

  assign Q        = OE_bar ? '0 : st;
  assign Q_oe     = ~OE_bar;
  assign QH_prime = sr[WIDTH-1];

endmodule
